div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_pkg.sv | 51 +++++
 rtl/div_perf.sv | 28 ++
 rtl/div_ctrl.sv | 155 +++++++++++++++
 tb/tb_div_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Divergence-control package: default widths, stack entry layout, type codes, FSM states.
// Entry layout: type[71:70], pc[69:38], mask in the low bits, every other bit zero.
// pack_entry/unpack_* are the only places that know the field offsets.
package div_pkg;

  localparam int NUM_LANES_DEF   = 8;
  localparam int PC_W_DEF        = 32;
  localparam int STACK_WIDTH_DEF = 72;

  localparam int TYPE_LSB   = 70;
  localparam int PC_LSB     = 38;
  localparam int MASK_LSB   = 0;
  localparam int MASK_MAX_W = PC_LSB - MASK_LSB;

  typedef enum logic [1:0] {
    ENT_UNIFORM = 2'd0,
    ENT_ELSE    = 2'd1,
    ENT_RESTORE = 2'd2
  } ent_type_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PUSH2     = 2'd1,
    JOIN_WAIT = 2'd2
  } state_e;

  typedef logic [STACK_WIDTH_DEF-1:0] entry_t;

  function automatic entry_t pack_entry(ent_type_e t, logic [PC_W_DEF-1:0] pc,
                                        logic [MASK_MAX_W-1:0] mask);
    entry_t e;
    e = '0;
    e[TYPE_LSB +: 2]          = t;
    e[PC_LSB +: PC_W_DEF]     = pc;
    e[MASK_LSB +: MASK_MAX_W] = mask;
    return e;
  endfunction

  function automatic ent_type_e unpack_type(entry_t e);
    return ent_type_e'(e[TYPE_LSB +: 2]);
  endfunction

  function automatic logic [PC_W_DEF-1:0] unpack_pc(entry_t e);
    return e[PC_LSB +: PC_W_DEF];
  endfunction

  function automatic logic [MASK_MAX_W-1:0] unpack_mask(entry_t e);
    return e[MASK_LSB +: MASK_MAX_W];
  endfunction

endpackage

// File: rtl/div_perf.sv
// Divergence performance counters: saturating divergent-split count and high-water depth.
// Latency: counters update one cycle after the event; no backpressure, purely observational.
// Ports: clk/rst, div_evt (accepted divergent split), depth (current), perf_div_cnt, perf_max_depth.
module div_perf #(
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_evt,
  input  logic [DEPTH_W-1:0] depth,
  output logic [15:0]        perf_div_cnt,
  output logic [DEPTH_W-1:0] perf_max_depth
);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_div_cnt   <= '0;
      perf_max_depth <= '0;
    end else begin
      // Saturate rather than wrap so a long run never reads as "few divergences".
      if (div_evt && (perf_div_cnt != 16'hFFFF))
        perf_div_cnt <= perf_div_cnt + 16'd1;
      if (depth > perf_max_depth)
        perf_max_depth <= depth;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// SIMD divergence controller: turns split/join requests into divergence-stack pushes/pops and mask/PC updates.
// Latency: stack commands issue in the accept cycle; mask/redirect/error outputs register one cycle later.
// Backpressure: ready=1 only in IDLE; requests seen while ready=0 are ignored, joins wait on stk_data_vld.
// Ports: split_*/join_vld requests in; mask_out, redirect_* out; stk_* drive/return from the stack;
// depth is the tracked occupancy; err_* are one-cycle pulses.
// Optional DIV_CTRL_PERF_EN adds perf_div_cnt/perf_max_depth via div_perf.
module div_ctrl
  import div_pkg::*;
#(
  parameter int NUM_LANES   = NUM_LANES_DEF,
  parameter int PC_W        = PC_W_DEF,
  parameter int STACK_DEPTH = 8,
  parameter int STACK_WIDTH = STACK_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         split_vld,
  input  logic [NUM_LANES-1:0]         split_pred,
  input  logic [PC_W-1:0]              split_pc,
  input  logic                         join_vld,
  output logic                         ready,
  output logic [NUM_LANES-1:0]         mask_out,
  output logic                         redirect_vld,
  output logic [PC_W-1:0]              redirect_pc,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [STACK_WIDTH-1:0]       stk_data_in,
  input  logic                         stk_data_vld,
  input  logic [STACK_WIDTH-1:0]       stk_data_out,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic                         err_proto
`ifdef DIV_CTRL_PERF_EN
  ,
  output logic [15:0]                  perf_div_cnt,
  output logic [$clog2(STACK_DEPTH):0] perf_max_depth
`endif
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  state_e               state;
  logic [NUM_LANES-1:0] taken, ntaken;
  logic [NUM_LANES-1:0] else_mask;
  logic [PC_W-1:0]      else_pc;
  logic                 divergent, split_acc, join_acc, proto, ovf;
  logic                 split_go, join_go;
  entry_t               push_entry, pop_entry;

  assign ready = (state == IDLE);

  always_comb begin
    taken     = mask_out & split_pred;
    ntaken    = mask_out & ~split_pred;
    divergent = (|taken) && (|ntaken);
    split_acc = ready && split_vld && !join_vld;
    join_acc  = ready && join_vld && !split_vld;
    proto     = ready && split_vld && join_vld;
    // A divergent split needs two free slots, a uniform one only one.
    ovf       = divergent ? (depth > DEPTH_W'(STACK_DEPTH - 2))
                          : (depth == DEPTH_W'(STACK_DEPTH));
    split_go  = split_acc && !ovf;
    join_go   = join_acc && (depth != '0);
  end

  // Stack strobes are combinational so the first push/pop lands in the accept
  // cycle; they are forced low under reset because the stack resets alongside.
  always_comb begin
    stk_push   = !rst && (split_go || (state == PUSH2));
    stk_pop    = !rst && join_go;
    push_entry = (state == PUSH2)
               ? pack_entry(ENT_ELSE, PC_W_DEF'(else_pc), MASK_MAX_W'(else_mask))
               : pack_entry(divergent ? ENT_RESTORE : ENT_UNIFORM, '0, MASK_MAX_W'(mask_out));
    pop_entry  = entry_t'(stk_data_out);
  end

  assign stk_data_in = STACK_WIDTH'(push_entry);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mask_out      <= '1;
      depth         <= '0;
      redirect_vld  <= 1'b0;
      redirect_pc   <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_proto     <= 1'b0;
      else_mask     <= '0;
      else_pc       <= '0;
    end else begin
      redirect_vld  <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_proto     <= 1'b0;

      // Push and pop never coincide: pushes come from IDLE/PUSH2, pops only from IDLE joins.
      if (stk_push)
        depth <= depth + 1'b1;
      else if (stk_pop)
        depth <= depth - 1'b1;

      case (state)
        IDLE: begin
          err_proto     <= proto;
          err_overflow  <= split_acc && ovf;
          err_underflow <= join_acc && (depth == '0);
          if (split_go) begin
            if (divergent) begin
              mask_out  <= taken;
              else_mask <= ntaken;
              else_pc   <= split_pc;
              state     <= PUSH2;
            end else if (taken == '0) begin
              // Nobody takes the branch: whole warp jumps to the else path.
              redirect_vld <= 1'b1;
              redirect_pc  <= split_pc;
            end
          end
          if (join_go)
            state <= JOIN_WAIT;
        end
        PUSH2: state <= IDLE;
        JOIN_WAIT: begin
          if (stk_data_vld) begin
            case (unpack_type(pop_entry))
              ENT_ELSE: begin
                mask_out     <= NUM_LANES'(unpack_mask(pop_entry));
                redirect_vld <= 1'b1;
                redirect_pc  <= PC_W'(unpack_pc(pop_entry));
              end
              ENT_RESTORE: mask_out <= NUM_LANES'(unpack_mask(pop_entry));
              default: ;
            endcase
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_CTRL_PERF_EN
  div_perf #(.DEPTH_W(DEPTH_W)) u_perf (
    .clk            (clk),
    .rst            (rst),
    .div_evt        (split_go && divergent),
    .depth          (depth),
    .perf_div_cnt   (perf_div_cnt),
    .perf_max_depth (perf_max_depth)
  );
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural divergence stack and programmable pop latency.
module tb_div_ctrl;

  localparam int NL = 8, PCW = 32, SD = 8, SW = 72;

  logic            clk = 1'b0, rst = 1'b1;
  logic            split_vld = 1'b0, join_vld = 1'b0;
  logic [NL-1:0]   split_pred = '0;
  logic [PCW-1:0]  split_pc = '0;
  logic            ready, redirect_vld, stk_push, stk_pop;
  logic [NL-1:0]   mask_out;
  logic [PCW-1:0]  redirect_pc;
  logic [SW-1:0]   stk_data_in;
  logic            stk_data_vld = 1'b0;
  logic [SW-1:0]   stk_data_out = '0;
  logic [3:0]      depth;
  logic            err_overflow, err_underflow, err_proto;
`ifdef DIV_CTRL_PERF_EN
  logic [15:0]     perf_div_cnt;
  logic [3:0]      perf_max_depth;
`endif

  int total = 0, bad = 0;
  int pop_lat = 1;
  logic [SW-1:0] mem [0:15];
  int sp = 0, pend_cnt = 0;
  logic [SW-1:0] pend_data = '0;

  always #5 clk = ~clk;

  div_ctrl #(.NUM_LANES(NL), .PC_W(PCW), .STACK_DEPTH(SD), .STACK_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .split_vld(split_vld), .split_pred(split_pred), .split_pc(split_pc),
    .join_vld(join_vld), .ready(ready), .mask_out(mask_out), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
    .stk_data_vld(stk_data_vld), .stk_data_out(stk_data_out), .depth(depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_proto(err_proto)
`ifdef DIV_CTRL_PERF_EN
    , .perf_div_cnt(perf_div_cnt), .perf_max_depth(perf_max_depth)
`endif
  );

  // Behavioural stack: pop data returns pop_lat cycles after the pop edge.
  always @(posedge clk) begin
    stk_data_vld <= 1'b0;
    if (rst) begin
      sp       <= 0;
      pend_cnt <= 0;
    end else begin
      if (stk_push) begin
        mem[sp] <= stk_data_in;
        sp      <= sp + 1;
      end
      if (pend_cnt != 0) begin
        pend_cnt <= pend_cnt - 1;
        if (pend_cnt == 1) begin
          stk_data_vld <= 1'b1;
          stk_data_out <= pend_data;
        end
      end
      if (stk_pop) begin
        pend_data <= mem[sp-1];
        pend_cnt  <= pop_lat;
        sp        <= sp - 1;
      end
    end
  end

  function automatic logic [71:0] mk(logic [1:0] t, logic [31:0] pc, logic [7:0] m);
    return {t, pc, 30'd0, m};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_uniform;
    split_vld = 1'b1; split_pred = 8'hFF; split_pc = 32'h0;
    tick;
    split_vld = 1'b0;
  endtask

  task automatic do_join(input int lat, output int k, output logic pop_seen);
    pop_lat = lat; join_vld = 1'b1;
    #1 pop_seen = stk_pop;
    tick;
    join_vld = 1'b0;
    k = 0;
    while (!ready && k < 20) begin
      tick;
      k++;
    end
    if (k >= 20) begin
      total++; bad++;
      $display("FAIL join_timeout ready low for %0d cycles, required <20", k);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    #1;
    total++;
    if ({ready, depth, mask_out, stk_push, stk_pop, redirect_vld, err_overflow, err_underflow, err_proto, redirect_pc}
        !== {1'b1, 4'd0, 8'hFF, 6'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b dep=%0d mask=%h push=%b pop=%b rv=%b errs=%b%b%b rpc=%h",
               ready, depth, mask_out, stk_push, stk_pop, redirect_vld, err_overflow, err_underflow, err_proto, redirect_pc);
    end
  endtask

  task automatic test_divergent;
    split_vld = 1'b1; split_pred = 8'h0F; split_pc = 32'h100;
    #1;
    total++;
    if ({ready, stk_push, stk_pop} !== 3'b110 || stk_data_in !== mk(2'd2, 32'h0, 8'hFF)) begin
      bad++; $display("FAIL div_restore_push got rdy/push/pop=%b%b%b data=%h exp data=%h",
                      ready, stk_push, stk_pop, stk_data_in, mk(2'd2, 32'h0, 8'hFF));
    end
    tick;  // PUSH2, split_vld deliberately held high: must be ignored
    total++;
    if ({ready, stk_push, mask_out} !== {1'b0, 1'b1, 8'h0F} || stk_data_in !== mk(2'd1, 32'h100, 8'hF0)) begin
      bad++; $display("FAIL div_else_push got rdy=%b push=%b mask=%h data=%h exp 0 1 0f %h",
                      ready, stk_push, mask_out, stk_data_in, mk(2'd1, 32'h100, 8'hF0));
    end
    tick;
    split_vld = 1'b0;
    #1;
    total++;
    if ({ready, stk_push, depth, mask_out, redirect_vld, err_overflow, err_underflow, err_proto}
        !== {1'b1, 1'b0, 4'd2, 8'h0F, 4'b0}) begin
      bad++; $display("FAIL div_after got rdy=%b push=%b dep=%0d mask=%h rv=%b errs=%b%b%b exp 1 0 2 0f 0 000",
                      ready, stk_push, depth, mask_out, redirect_vld, err_overflow, err_underflow, err_proto);
    end
  endtask

  task automatic test_join;
    int k;
    logic p;
    do_join(3, k, p);
    total++;
    if (p !== 1'b1 || k != 4) begin
      bad++; $display("FAIL join1_timing got pop=%b wait=%0d exp pop=1 wait=4", p, k);
    end
    total++;
    if ({mask_out, redirect_vld, redirect_pc, depth} !== {8'hF0, 1'b1, 32'h100, 4'd1}) begin
      bad++; $display("FAIL join1_else got mask=%h rv=%b rpc=%h dep=%0d exp f0 1 100 1",
                      mask_out, redirect_vld, redirect_pc, depth);
    end
    tick;
    total++;
    if (redirect_vld !== 1'b0) begin
      bad++; $display("FAIL join1_pulse redirect_vld=%b exp 0", redirect_vld);
    end
    do_join(1, k, p);
    total++;
    if ({p, mask_out, redirect_vld, depth} !== {1'b1, 8'hFF, 1'b0, 4'd0} || k != 2) begin
      bad++; $display("FAIL join2_restore got pop=%b mask=%h rv=%b dep=%0d wait=%0d exp 1 ff 0 0 2",
                      p, mask_out, redirect_vld, depth, k);
    end
  endtask

  task automatic test_uniform;
    int k;
    logic p;
    split_vld = 1'b1; split_pred = 8'hFF; split_pc = 32'h300;
    #1;
    total++;
    if (stk_push !== 1'b1 || stk_data_in !== mk(2'd0, 32'h0, 8'hFF)) begin
      bad++; $display("FAIL uni_all_push got push=%b data=%h exp 1 %h", stk_push, stk_data_in, mk(2'd0, 32'h0, 8'hFF));
    end
    tick;
    split_vld = 1'b0;
    #1;
    total++;
    if ({ready, stk_push, depth, mask_out, redirect_vld} !== {1'b1, 1'b0, 4'd1, 8'hFF, 1'b0}) begin
      bad++; $display("FAIL uni_all_after got rdy=%b push=%b dep=%0d mask=%h rv=%b exp 1 0 1 ff 0",
                      ready, stk_push, depth, mask_out, redirect_vld);
    end
    split_vld = 1'b1; split_pred = 8'h00; split_pc = 32'h200;
    #1;
    total++;
    if (stk_push !== 1'b1 || stk_data_in !== mk(2'd0, 32'h0, 8'hFF)) begin
      bad++; $display("FAIL uni_none_push got push=%b data=%h", stk_push, stk_data_in);
    end
    tick;
    split_vld = 1'b0;
    total++;
    if ({redirect_vld, redirect_pc, depth, mask_out} !== {1'b1, 32'h200, 4'd2, 8'hFF}) begin
      bad++; $display("FAIL uni_none_redirect got rv=%b rpc=%h dep=%0d mask=%h exp 1 200 2 ff",
                      redirect_vld, redirect_pc, depth, mask_out);
    end
    tick;
    total++;
    if (redirect_vld !== 1'b0) begin
      bad++; $display("FAIL uni_none_pulse redirect_vld=%b exp 0", redirect_vld);
    end
    do_join(1, k, p);
    total++;
    if ({p, mask_out, redirect_vld, depth} !== {1'b1, 8'hFF, 1'b0, 4'd1}) begin
      bad++; $display("FAIL uni_join1 got pop=%b mask=%h rv=%b dep=%0d exp 1 ff 0 1", p, mask_out, redirect_vld, depth);
    end
    do_join(2, k, p);
    total++;
    if ({mask_out, redirect_vld, depth} !== {8'hFF, 1'b0, 4'd0}) begin
      bad++; $display("FAIL uni_join2 got mask=%h rv=%b dep=%0d exp ff 0 0", mask_out, redirect_vld, depth);
    end
  endtask

  task automatic test_overflow_underflow;
    int k;
    logic p;
    repeat (7) push_uniform;
    #1;
    total++;
    if (depth !== 4'd7) begin
      bad++; $display("FAIL ovf_fill depth=%0d exp 7", depth);
    end
    split_vld = 1'b1; split_pred = 8'h0F; split_pc = 32'h400;
    #1;
    total++;
    if (stk_push !== 1'b0) begin
      bad++; $display("FAIL ovf_div_nopush push=%b exp 0", stk_push);
    end
    tick;
    split_vld = 1'b0;
    #1;
    total++;
    if ({err_overflow, depth, mask_out, ready, stk_push} !== {1'b1, 4'd7, 8'hFF, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ovf_div got err=%b dep=%0d mask=%h rdy=%b push=%b exp 1 7 ff 1 0",
                      err_overflow, depth, mask_out, ready, stk_push);
    end
    tick;
    total++;
    if (err_overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_pulse err_overflow=%b exp 0", err_overflow);
    end
    push_uniform;  // uniform at depth 7 still fits
    #1;
    total++;
    if ({depth, err_overflow} !== {4'd8, 1'b0}) begin
      bad++; $display("FAIL ovf_uni_fit dep=%0d err=%b exp 8 0", depth, err_overflow);
    end
    split_vld = 1'b1; split_pred = 8'hFF;
    #1;
    total++;
    if (stk_push !== 1'b0) begin
      bad++; $display("FAIL ovf_uni_nopush push=%b exp 0", stk_push);
    end
    tick;
    split_vld = 1'b0;
    total++;
    if ({err_overflow, depth} !== {1'b1, 4'd8}) begin
      bad++; $display("FAIL ovf_uni got err=%b dep=%0d exp 1 8", err_overflow, depth);
    end
    repeat (8) do_join(1, k, p);
    total++;
    if ({depth, mask_out} !== {4'd0, 8'hFF}) begin
      bad++; $display("FAIL ovf_drain dep=%0d mask=%h exp 0 ff", depth, mask_out);
    end
    join_vld = 1'b1;
    #1;
    total++;
    if (stk_pop !== 1'b0) begin
      bad++; $display("FAIL unf_nopop pop=%b exp 0", stk_pop);
    end
    tick;
    join_vld = 1'b0;
    total++;
    if ({err_underflow, err_overflow, ready, depth} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
      bad++; $display("FAIL unf_pulse got unf=%b ovf=%b rdy=%b dep=%0d exp 1 0 1 0",
                      err_underflow, err_overflow, ready, depth);
    end
    tick;
    total++;
    if (err_underflow !== 1'b0) begin
      bad++; $display("FAIL unf_clear err_underflow=%b exp 0", err_underflow);
    end
  endtask

  task automatic test_proto;
    int k;
    logic p;
    push_uniform;
    split_vld = 1'b1; join_vld = 1'b1; split_pred = 8'h0F; split_pc = 32'h600;
    #1;
    total++;
    if ({stk_push, stk_pop} !== 2'b00) begin
      bad++; $display("FAIL proto_nocmd push=%b pop=%b exp 0 0", stk_push, stk_pop);
    end
    tick;
    split_vld = 1'b0; join_vld = 1'b0;
    total++;
    if ({err_proto, err_overflow, err_underflow, ready, depth, mask_out, redirect_vld}
        !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 8'hFF, 1'b0}) begin
      bad++; $display("FAIL proto_pulse got proto=%b ovf=%b unf=%b rdy=%b dep=%0d mask=%h rv=%b exp 1 0 0 1 1 ff 0",
                      err_proto, err_overflow, err_underflow, ready, depth, mask_out, redirect_vld);
    end
    tick;
    total++;
    if (err_proto !== 1'b0) begin
      bad++; $display("FAIL proto_clear err_proto=%b exp 0", err_proto);
    end
    do_join(1, k, p);
  endtask

  task automatic test_reset_mid;
    split_vld = 1'b1; split_pred = 8'h0F; split_pc = 32'h500;
    tick;
    split_vld = 1'b0;
    rst = 1'b1;  // mid-PUSH2
    #1;
    total++;
    if ({stk_push, stk_pop} !== 2'b00) begin
      bad++; $display("FAIL rst_strobes push=%b pop=%b exp 0 0", stk_push, stk_pop);
    end
    tick;
    rst = 1'b0;
    total++;
    if ({ready, depth, mask_out, stk_push} !== {1'b1, 4'd0, 8'hFF, 1'b0}) begin
      bad++; $display("FAIL rst_push2 got rdy=%b dep=%0d mask=%h push=%b exp 1 0 ff 0", ready, depth, mask_out, stk_push);
    end
    push_uniform;
    pop_lat = 6; join_vld = 1'b1;
    tick;
    join_vld = 1'b0;
    tick;
    rst = 1'b1;  // mid-JOIN_WAIT
    tick;
    rst = 1'b0;
    pop_lat = 1;
    repeat (6) tick;
    total++;
    if ({ready, depth, mask_out, redirect_vld} !== {1'b1, 4'd0, 8'hFF, 1'b0}) begin
      bad++; $display("FAIL rst_joinwait got rdy=%b dep=%0d mask=%h rv=%b exp 1 0 ff 0", ready, depth, mask_out, redirect_vld);
    end
  endtask

  initial begin
    test_reset;
    test_divergent;
    test_join;
    test_uniform;
    test_overflow_underflow;
    test_proto;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
